// File: rtl/lpf_capture_buffer.sv
// Triggered capture of the 8-sample filter output word into a block RAM ring,
// replayed one sample per beat over a valid/ready stream.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no writes; waiting for arm_i
// S_ARMED   | writing the ring every cycle; trigger qualified once PRE words exist
// S_POST    | writing post-trigger words until LEN-PRE words are written
// S_READOUT | streaming LEN*NSAMP samples from (tptr - PRE), oldest first
module lpf_capture_buffer #(
  parameter int NBITS     = 13,
  parameter int NSAMP     = 8,
  parameter int ADDR_BITS = 9,
  parameter int PRE       = 16,
  parameter int LEN       = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NSAMP*NBITS-1:0] dat_i,
  input  logic                   arm_i,
  input  logic                   trig_i,
  output logic [NBITS-1:0]       m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [1:0]             state_o,
  output logic                   done_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int WW    = NSAMP * NBITS;
  localparam int SW    = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int PW    = $clog2(PRE + 1);
  localparam int CW    = $clog2(LEN + 1);
  localparam int BW    = $clog2(LEN * NSAMP + 1);

  localparam logic [PW-1:0]        PRE_C     = PW'(PRE);
  localparam logic [ADDR_BITS-1:0] PRE_A     = ADDR_BITS'(PRE);
  localparam logic [CW-1:0]        LEN_C     = CW'(LEN);
  localparam logic [CW-1:0]        POST_LAST = CW'(LEN - PRE - 1);
  localparam logic [BW-1:0]        BEAT_LAST = BW'(LEN * NSAMP - 1);
  localparam logic [SW-1:0]        SAMP_LAST = SW'(NSAMP - 1);

  if (PRE < 1 || PRE >= LEN || LEN > DEPTH) begin : g_bad_params
    $error("lpf_capture_buffer: parameters must satisfy 1 <= PRE < LEN <= 2**ADDR_BITS");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_POST    = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WW-1:0]        mem [DEPTH];
  logic [WW-1:0]        rd_q, word_q;
  logic [ADDR_BITS-1:0] wptr, rd_ptr;
  logic [CW-1:0]        fetch_left, post_cnt;
  logic [PW-1:0]        pre_cnt;
  logic [BW-1:0]        beat_cnt;
  logic [SW-1:0]        samp_idx;
  logic                 pf_valid, word_valid, done_q;

  logic pre_full, qual, we, accept, word_end, last_acc, load, issue;

  always_comb begin
    pre_full = (pre_cnt == PRE_C);
    qual     = (state_q == S_ARMED) && trig_i && pre_full;
    we       = (state_q == S_ARMED) || (state_q == S_POST);
    accept   = word_valid && m_tready;
    word_end = accept && (samp_idx == SAMP_LAST);
    last_acc = accept && (beat_cnt == BEAT_LAST);
    // rd_q acts as a one-word prefetch slot, refilled as soon as it is consumed
    load     = pf_valid && (!word_valid || word_end);
    issue    = (state_q == S_READOUT) && (fetch_left != '0) && (!pf_valid || load);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm_i) state_d = S_ARMED;
      S_ARMED:   if (qual) state_d = (LEN - PRE == 1) ? S_READOUT : S_POST;
      S_POST:    if (post_cnt == POST_LAST) state_d = S_READOUT;
      S_READOUT: if (last_acc) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr       <= '0;
      rd_ptr     <= '0;
      fetch_left <= '0;
      post_cnt   <= '0;
      pre_cnt    <= '0;
      beat_cnt   <= '0;
      samp_idx   <= '0;
      word_q     <= '0;
      pf_valid   <= 1'b0;
      word_valid <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_acc;
      case (state_q)
        S_IDLE: if (arm_i) pre_cnt <= '0;
        S_ARMED: begin
          wptr <= wptr + ADDR_BITS'(1);
          if (!pre_full) pre_cnt <= pre_cnt + PW'(1);
          if (qual) begin
            rd_ptr     <= wptr - PRE_A;
            fetch_left <= LEN_C;
            post_cnt   <= CW'(1);
            beat_cnt   <= '0;
          end
        end
        S_POST: begin
          wptr     <= wptr + ADDR_BITS'(1);
          post_cnt <= post_cnt + CW'(1);
        end
        S_READOUT: begin
          if (issue) begin
            rd_ptr     <= rd_ptr + ADDR_BITS'(1);
            fetch_left <= fetch_left - CW'(1);
          end
          if (issue)     pf_valid <= 1'b1;
          else if (load) pf_valid <= 1'b0;
          if (load) begin
            word_q     <= rd_q;
            samp_idx   <= '0;
            word_valid <= 1'b1;
          end else if (word_end) begin
            word_valid <= 1'b0;
          end else if (accept) begin
            samp_idx <= samp_idx + SW'(1);
          end
          if (accept) beat_cnt <= beat_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (we && !rst_i) mem[wptr] <= dat_i;
    if (issue)        rd_q <= mem[rd_ptr];
  end

  assign m_tvalid = word_valid;
  assign m_tdata  = word_valid ? word_q[int'(samp_idx) * NBITS +: NBITS] : '0;
  assign m_tlast  = word_valid && (beat_cnt == BEAT_LAST);
  assign state_o  = state_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_lpf_capture_buffer.sv
// Directed capture scenarios with randomized data/backpressure, checked against
// a window model built from the list of words fed to the buffer.
module tb_lpf_capture_buffer;
  localparam int NBITS = 13, NSAMP = 8, ADDR_BITS = 9, PRE = 16, LEN = 64;
  localparam int NBEAT = LEN * NSAMP;
  localparam int WW    = NSAMP * NBITS;

  logic             clk = 1'b0;
  logic             rst, arm, trig, m_tready;
  logic [WW-1:0]    dat;
  logic [NBITS-1:0] m_tdata;
  logic             m_tvalid, m_tlast, done;
  logic [1:0]       state;

  int vectors = 0;
  int errors  = 0;
  logic [WW-1:0] wr_q [$];

  always #5 clk = ~clk;

  lpf_capture_buffer #(.NBITS(NBITS), .NSAMP(NSAMP), .ADDR_BITS(ADDR_BITS), .PRE(PRE), .LEN(LEN)) dut (
    .clk_i(clk), .rst_i(rst), .dat_i(dat), .arm_i(arm), .trig_i(trig),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .state_o(state), .done_o(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: zeros, trigger pattern at word 16, then counter; 1: random; 2: counter
  function automatic logic [WW-1:0] make_word(input int mode, input int n);
    logic [WW-1:0]    w;
    logic [NBITS-1:0] s;
    w = '0;
    for (int k = 0; k < NSAMP; k++) begin
      case (mode)
        0: begin
          if (n < 16)          s = '0;
          else if (n == 16)    s = (k % 2 == 0) ? NBITS'(0) : ((k % 4 == 1) ? NBITS'(2047) : NBITS'(-4096));
          else                 s = NBITS'(n * NSAMP + k);
        end
        1:       s = NBITS'($urandom);
        default: s = NBITS'(n * NSAMP + k);
      endcase
      w[NBITS*k +: NBITS] = s;
    end
    return w;
  endfunction

  task automatic capture(input int mode, input int trig_n, input int early_n, input bit bp,
                         input bit noise, input int abort_at, input bit trig_with_arm);
    int tn, n_words, idx, cyc, first_cyc, dones;
    bit stalled;
    logic [NBITS-1:0] held, expv;
    logic [WW-1:0] w;
    wr_q.delete();
    arm = 1'b1; trig = trig_with_arm; m_tready = 1'b0;
    step();
    arm = 1'b0; trig = 1'b0;
    check("armed", 32'(state), 1);
    // trigger is the first asserted word with at least PRE words already written
    tn = (early_n >= PRE) ? early_n : trig_n;
    n_words = tn + LEN - PRE;
    for (int n = 0; n < n_words; n++) begin
      w = make_word(mode, n);
      dat = w;
      wr_q.push_back(w);
      trig = (n == trig_n) || (n == early_n);
      arm  = noise && (n > tn) && ($urandom_range(1, 0) == 1);
      step();
      if (n == tn) check("post_entry", 32'(state), 2);
    end
    trig = 1'b0; arm = 1'b0; dat = make_word(1, 0);
    check("readout_entry", 32'(state), 3);
    idx = 0; cyc = 0; first_cyc = -1; dones = 0; stalled = 1'b0; held = '0;
    while (idx < NBEAT && cyc < 4000) begin
      if (done) dones++;
      if (m_tvalid && first_cyc < 0) first_cyc = cyc;
      if (stalled) begin
        check("stall_valid", 32'(m_tvalid), 1);
        check("stall_data", 32'(m_tdata), 32'(held));
      end
      m_tready = bp ? ($urandom_range(1, 0) == 1) : 1'b1;
      arm  = noise && ($urandom_range(1, 0) == 1);
      trig = noise && ($urandom_range(1, 0) == 1);
      if (abort_at >= 0 && idx == abort_at) begin
        check("pre_reset_valid", 32'(m_tvalid), 1);
        rst = 1'b1; m_tready = 1'b0;
        step();
        rst = 1'b0;
        check("reset_valid", 32'(m_tvalid), 0);
        check("reset_state", 32'(state), 0);
        check("reset_done", 32'(done), 0);
        repeat (3) begin
          step();
          check("reset_no_done", 32'(done), 0);
          check("reset_no_valid", 32'(m_tvalid), 0);
        end
        return;
      end
      stalled = m_tvalid && !m_tready;
      held = m_tdata;
      if (m_tvalid && m_tready) begin
        w = wr_q[tn - PRE + idx / NSAMP];
        expv = w[NBITS*(idx % NSAMP) +: NBITS];
        check("beat_data", 32'(m_tdata), 32'(expv));
        check("beat_tlast", 32'(m_tlast), 32'(idx == NBEAT - 1));
        idx++;
      end
      step();
      cyc++;
    end
    arm = 1'b0; trig = 1'b0;
    check("beat_count", 32'(idx), NBEAT);
    check("first_valid_latency_ok", 32'(first_cyc >= 0 && first_cyc <= 3), 1);
    check("done_pulse", 32'(done), 1);
    check("valid_drop", 32'(m_tvalid), 0);
    check("back_to_idle", 32'(state), 0);
    check("no_early_done", 32'(dones), 0);
    m_tready = 1'b1;
    step();
    check("done_single", 32'(done), 0);
    check("no_extra_beat", 32'(m_tvalid), 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig = 1'b0; m_tready = 1'b0; dat = '0;
    step();
    step();
    check("rst_state", 32'(state), 0);
    check("rst_valid", 32'(m_tvalid), 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tdata", 32'(m_tdata), 0);
    rst = 1'b0;

    trig = 1'b1;
    repeat (5) begin
      step();
      check("idle_trig_state", 32'(state), 0);
      check("idle_trig_valid", 32'(m_tvalid), 0);
    end
    trig = 1'b0;

    capture(0, 16, -1, 1'b0, 1'b0, -1, 1'b0);    // pattern capture
    capture(1, 19, 4, 1'b0, 1'b0, -1, 1'b1);     // early trigger, arm+trig together in idle
    capture(0, 16, -1, 1'b1, 1'b0, -1, 1'b0);    // pattern under backpressure
    capture(2, 1000, -1, 1'b0, 1'b0, -1, 1'b0);  // ring wrap
    capture(1, 40, -1, 1'b1, 1'b1, -1, 1'b0);    // arm/trig noise in post/readout
    capture(1, 30, -1, 1'b0, 1'b0, 100, 1'b0);   // reset mid-readout
    capture(1, 20, -1, 1'b1, 1'b0, -1, 1'b0);    // re-arm after reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
